mult_control_n: RTL and testbench
=================================

# mult_control_n

Parametrised control unit for the signed shift-add multiplier datapath. It replaces the fixed 8-bit sequencer. It sequences the clear, test, add, subtract and shift steps for a WIDTH-bit two's-complement multiplier held in the B register: add for the first WIDTH-1 set bits, subtract for the sign bit. It sits between the debounced Execute switch and the X/A/B register and adder-subtractor datapath, and adds Busy, Done and iteration-count status plus an optional chained-multiply mode.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; legal range 2..64.
- CW, $clog2(WIDTH+1), width of the Count output; derived, not overridden.

Ports:
- Clk  in  1  rising-edge clock; the only clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Execute  in  1  level start request, already synchronised to Clk.
- M  in  1  multiplier bit under test (B[0]).
- Clr_XA  out  1  clears X and A, asserted in CLEAR only.
- Ld_A  out  1  loads A with A+S, asserted in ADD only.
- Ld_Sub  out  1  loads A with A−S, asserted in SUB only.
- Shift_En  out  1  arithmetic right shift of X:A:B, asserted in SHIFT only.
- Busy  out  1  high in CLEAR, TEST, ADD, SUB and SHIFT.
- Done  out  1  high in HOLD.
- Count  out  CW  number of shifts completed in the current operation.

## Operation
- The block is a Moore FSM. Outputs decode the registered state and the registered counter only, with no input-to-output paths.
- States: IDLE, CLEAR, TEST, ADD, SUB, SHIFT, HOLD.
- IDLE: when Execute=1, go to CLEAR; otherwise stay.
- CLEAR: Count←0; go to TEST.
- TEST: with M=1 and Count<WIDTH-1, go to ADD. With M=1 and Count==WIDTH-1, go to SUB. With M=0, go to SHIFT.
- ADD and SUB: go to SHIFT.
- SHIFT: Count←Count+1. If the pre-increment Count equals WIDTH-1, go to HOLD; otherwise go to TEST.
- HOLD: when Execute=0, go to IDLE. Behaviour with Execute still high is set under Configuration.
- At most one of Clr_XA, Ld_A, Ld_Sub and Shift_En is high in any cycle.
- Count saturates at WIDTH in HOLD. It holds its value in IDLE and is cleared only by CLEAR or reset.
- Illegal or unreached state encodings recover to IDLE on the next edge, with all strobes low.

## Timing
- Reset: on Reset_n low, with no clock needed, the state becomes IDLE and Count becomes 0. All outputs go to 0.
- Reset asserted mid-operation aborts immediately. No further strobes are issued. After Reset_n rises, a new operation needs Execute high while in IDLE.
- Start latency: Execute is sampled high at edge n, and CLEAR occupies cycle n+1.
- Per-operation length from CLEAR entry to HOLD entry is 1 + 2·WIDTH + k cycles, where k is the number of M=1 samples seen in TEST (0..WIDTH).
- Execute changes during Busy are ignored.
- M is sampled only in TEST, and the datapath must hold it stable through that cycle.

## Configuration
- Macro: MULT_CTRL_REPEAT_EN.
- Undefined:
  - HOLD waits for Execute=0, then goes to IDLE.
  - One multiply is performed per Execute assertion.
- Defined:
  - In HOLD, with Execute=1 for one full cycle, the FSM goes from HOLD to CLEAR after exactly one HOLD cycle. Done is high for that single cycle.
  - Multiplies then chain continuously, each using the previous low product in B as the new multiplier.
  - Execute=0 in HOLD goes to IDLE exactly as in the undefined case.

## Test plan
- Reset: Reset_n low mid-SHIFT, asynchronously between edges, with WIDTH=8 → all outputs read 0 before the next edge, and the FSM is in IDLE after release.
- Zero multiplier: WIDTH=8, M=0 throughout, Execute pulsed high for 1 cycle then low.
  - Response: Clr_XA for 1 cycle, then 8 Shift_En pulses, no Ld_A or Ld_Sub.
  - Done rises 17 cycles after CLEAR entry, and Count=8.
- All ones: WIDTH=8, M=1 throughout.
  - Response: 7 Ld_A pulses, then 1 Ld_Sub on the eighth bit, 8 Shift_En pulses.
  - HOLD is reached 25 cycles after CLEAR entry.
- Parameter sweep: WIDTH=2 and WIDTH=16 with M=1,0 alternating.
  - WIDTH=2: 1 Ld_Sub when the sign bit is 1, otherwise 0; HOLD after 5 + (ones seen) cycles.
  - WIDTH=16: Ld_A count matches the set bits below the sign bit, and Ld_Sub matches the sign bit; HOLD after 33 + (ones seen) cycles.
- Execute held high with MULT_CTRL_REPEAT_EN undefined: FSM stays in HOLD with Done=1 until Execute falls. With it defined: exactly 1 Done cycle, then Clr_XA the next cycle.
- Execute toggled during Busy (WIDTH=8): strobe sequence and length are unchanged from the undisturbed run.

Source files
------------

// File: rtl/mult_control_n_if.sv
// rtl/mult_control_n_if.sv - control/status bundle between mult_control_n and the multiplier datapath
//
// Signals:
//   Execute  - start request from the debounced switch (into the controller)
//   M        - multiplier bit under test, B[0] (into the controller)
//   Clr_XA   - clear X and A strobe
//   Ld_A     - load A with A+S strobe
//   Ld_Sub   - load A with A-S strobe
//   Shift_En - arithmetic right shift of X:A:B strobe
//   Busy     - operation in progress
//   Done     - product ready (HOLD)
//   Count    - shifts completed in the current operation
// Modports: master = controller side, slave = datapath/requester side.
interface mult_control_n_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic          Execute;
  logic          M;
  logic          Clr_XA;
  logic          Ld_A;
  logic          Ld_Sub;
  logic          Shift_En;
  logic          Busy;
  logic          Done;
  logic [CW-1:0] Count;

  modport master (
    input  Execute,
    input  M,
    output Clr_XA,
    output Ld_A,
    output Ld_Sub,
    output Shift_En,
    output Busy,
    output Done,
    output Count
  );

  modport slave (
    output Execute,
    output M,
    input  Clr_XA,
    input  Ld_A,
    input  Ld_Sub,
    input  Shift_En,
    input  Busy,
    input  Done,
    input  Count
  );
endinterface

// File: rtl/mult_control_n.sv
// rtl/mult_control_n.sv - sequencer for a WIDTH-bit signed shift-add multiplier datapath
//
// Moore FSM issuing clear/add/subtract/shift strobes for a two's-complement
// multiplier held in B: add for set bits below the sign bit, subtract for a set
// sign bit, one arithmetic shift per bit.
//
// Ports:
//   Clk     - rising-edge clock
//   Reset_n - asynchronous active-low reset
//   bus     - mult_control_n_if.master (Execute, M in; Clr_XA, Ld_A, Ld_Sub,
//             Shift_En, Busy, Done, Count out)
//
// Optional feature macro: MULT_CTRL_REPEAT_EN
//   undefined - HOLD waits for Execute=0, one multiply per Execute assertion
//   defined   - Execute still high in HOLD restarts at CLEAR after one HOLD cycle
module mult_control_n #(
  parameter int WIDTH = 8
) (
  input  logic              Clk,
  input  logic              Reset_n,
  mult_control_n_if.master  bus
);
  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_TEST  = 3'd2,
    S_ADD   = 3'd3,
    S_SUB   = 3'd4,
    S_SHIFT = 3'd5,
    S_HOLD  = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          clr_q, lda_q, lsub_q, shift_q, busy_q, done_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (bus.Execute) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        count_d = '0;
        state_d = S_TEST;
      end
      S_TEST: begin
        // The last bit examined is the sign bit, which carries negative weight.
        if (bus.M) state_d = (count_q == LAST) ? S_SUB : S_ADD;
        else       state_d = S_SHIFT;
      end
      S_ADD, S_SUB: begin
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        // Reaches WIDTH on the final shift and then stays there through HOLD.
        count_d = count_q + ONE;
        state_d = (count_q == LAST) ? S_HOLD : S_TEST;
      end
      S_HOLD: begin
        if (!bus.Execute) begin
          state_d = S_IDLE;
        end else begin
`ifdef MULT_CTRL_REPEAT_EN
          state_d = S_CLEAR;
`else
          state_d = S_HOLD;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with
  // the state register and never depend combinationally on Execute or M.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      clr_q   <= 1'b0;
      lda_q   <= 1'b0;
      lsub_q  <= 1'b0;
      shift_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      clr_q   <= (state_d == S_CLEAR);
      lda_q   <= (state_d == S_ADD);
      lsub_q  <= (state_d == S_SUB);
      shift_q <= (state_d == S_SHIFT);
      busy_q  <= (state_d == S_CLEAR) || (state_d == S_TEST) || (state_d == S_ADD) ||
                 (state_d == S_SUB)   || (state_d == S_SHIFT);
      done_q  <= (state_d == S_HOLD);
    end
  end

  assign bus.Clr_XA   = clr_q;
  assign bus.Ld_A     = lda_q;
  assign bus.Ld_Sub   = lsub_q;
  assign bus.Shift_En = shift_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.Count    = count_q;
endmodule

// File: tb/tb_mult_control_n.sv
// tb/tb_mult_control_n.sv - scoreboard bench for mult_control_n at WIDTH 2, 8 and 16
module tb_mult_control_n;
  typedef struct {
    int inst;
    int lda;
    int sub;
    int len;
  } exp_t;

  logic        clk = 1'b0;
  logic        exec    [3];
  logic        rstn    [3];
  logic [15:0] bval    [3];
  logic        clr_w   [3];
  logic        lda_w   [3];
  logic        sub_w   [3];
  logic        sh_w    [3];
  logic        busy_w  [3];
  logic        done_w  [3];
  logic [7:0]  count_w [3];
  int          wid     [3] = '{2, 8, 16};

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endfunction

  for (genvar I = 0; I < 3; I++) begin : g_inst
    localparam int W = (I == 0) ? 2 : (I == 1) ? 8 : 16;

    mult_control_n_if #(.WIDTH(W)) ifc ();

    mult_control_n #(.WIDTH(W)) u_dut (
      .Clk     (clk),
      .Reset_n (rstn[I]),
      .bus     (ifc)
    );

    assign ifc.Execute = exec[I];
    assign clr_w[I]    = ifc.Clr_XA;
    assign lda_w[I]    = ifc.Ld_A;
    assign sub_w[I]    = ifc.Ld_Sub;
    assign sh_w[I]     = ifc.Shift_En;
    assign busy_w[I]   = ifc.Busy;
    assign done_w[I]   = ifc.Done;
    assign count_w[I]  = 8'(ifc.Count);

    logic [15:0] b = '0;
    int  cyc, nclr, nlda, nsub, nsh;
    bit  in_op, multi, busy_bad, done_seen;
    exp_t e;

    // Datapath model driving M plus the monitor that scores each finished operation.
    always @(negedge clk) begin
      if (!rstn[I]) begin
        in_op     = 1'b0;
        done_seen = 1'b0;
        ifc.M     = 1'b0;
      end else begin
        if (ifc.Clr_XA) begin
          in_op = 1'b1; cyc = 0; nclr = 0; nlda = 0; nsub = 0; nsh = 0;
          multi = 1'b0; busy_bad = 1'b0;
          b = bval[I];
        end else begin
          cyc++;
        end
        if (in_op) begin
          nclr += int'(ifc.Clr_XA);
          nlda += int'(ifc.Ld_A);
          nsub += int'(ifc.Ld_Sub);
          nsh  += int'(ifc.Shift_En);
          if (int'(ifc.Clr_XA) + int'(ifc.Ld_A) + int'(ifc.Ld_Sub) + int'(ifc.Shift_En) > 1)
            multi = 1'b1;
          if (!ifc.Done && !ifc.Busy) busy_bad = 1'b1;
        end
        if (ifc.Shift_En) b = b >> 1;
        ifc.M = b[0];
        if (ifc.Done && !done_seen && in_op) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_done inst=%0d: got done expected none", I);
          end else begin
            e = exp_q.pop_front();
            check("inst", I, e.inst);
            check("length", cyc, e.len);
            check("ld_a_count", nlda, e.lda);
            check("ld_sub_count", nsub, e.sub);
            check("shift_count", nsh, W);
            check("clr_count", nclr, 1);
            check("one_hot", multi, 0);
            check("busy_track", {busy_bad, ifc.Busy}, 0);
            check("done_count", ifc.Count, W);
          end
          in_op = 1'b0;
        end
        done_seen = ifc.Done;
      end
    end
  end

  task automatic wait_done(int i);
    int k = 0;
    while (!done_w[i] && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("op_done", done_w[i], 1);
  endtask

  // mode 0: one-cycle Execute pulse, 1: Execute toggled while busy, 2: Execute held high
  task automatic run_op(int i, logic [15:0] b, int lda, int sub, int len, int mode);
    exp_t ex;
    ex.inst = i; ex.lda = lda; ex.sub = sub; ex.len = len;
    bval[i] = b;
    exp_q.push_back(ex);
`ifdef MULT_CTRL_REPEAT_EN
    if (mode == 2) exp_q.push_back(ex);
`endif
    @(negedge clk);
    exec[i] = 1'b1;
    @(negedge clk);
    check("start_latency", clr_w[i], 1);
    if (mode != 2) exec[i] = 1'b0;
    if (mode == 1) begin
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        exec[i] = ~exec[i];
      end
      exec[i] = 1'b0;
    end
    wait_done(i);
    if (mode == 2) begin
`ifdef MULT_CTRL_REPEAT_EN
      @(negedge clk);
      check("repeat_restart", {clr_w[i], done_w[i]}, 2'b10);
      exec[i] = 1'b0;
      wait_done(i);
`else
      repeat (4) @(negedge clk);
      check("hold_stays", {done_w[i], busy_w[i]}, 2'b10);
      exec[i] = 1'b0;
`endif
    end
    @(negedge clk);
    check("back_to_idle", {done_w[i], busy_w[i]}, 0);
    check("count_held", count_w[i], wid[i]);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rstn[i] = 1'b0; exec[i] = 1'b0; bval[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_strobes", {clr_w[i], lda_w[i], sub_w[i], sh_w[i], busy_w[i], done_w[i]}, 0);
      check("reset_count", count_w[i], 0);
    end
    #2;
    for (int i = 0; i < 3; i++) rstn[i] = 1'b1;

    // WIDTH=8
    run_op(1, 16'h0000, 0, 0, 17, 0);
    run_op(1, 16'h00FF, 7, 1, 25, 0);
    run_op(1, 16'h0096, 3, 1, 21, 0);
    run_op(1, 16'h0035, 4, 0, 21, 0);
    // WIDTH=2
    run_op(0, 16'h0001, 1, 0, 6, 0);
    run_op(0, 16'h0002, 0, 1, 6, 0);
    run_op(0, 16'h0003, 1, 1, 7, 0);
    run_op(0, 16'h0000, 0, 0, 5, 0);
    // WIDTH=16
    run_op(2, 16'h5555, 8, 0, 41, 0);
    run_op(2, 16'hAAAA, 7, 1, 41, 0);
    run_op(2, 16'h8001, 1, 1, 35, 0);

    // Execute toggled while busy: same strobes and length as the quiet run
    run_op(1, 16'h0096, 3, 1, 21, 1);

    // Execute held high through HOLD
    run_op(1, 16'h0035, 4, 0, 21, 2);

    // Asynchronous reset in the middle of a SHIFT cycle
    bval[1] = 16'h0000;
    @(negedge clk);
    exec[1] = 1'b1;
    @(negedge clk);
    exec[1] = 1'b0;
    for (int k = 0; k < 50 && !sh_w[1]; k++) @(negedge clk);
    check("reached_shift", sh_w[1], 1);
    #2;
    rstn[1] = 1'b0;
    #1;
    check("async_reset_strobes", {clr_w[1], lda_w[1], sub_w[1], sh_w[1], busy_w[1], done_w[1]}, 0);
    check("async_reset_count", count_w[1], 0);
    repeat (2) @(negedge clk);
    #2;
    rstn[1] = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_reset", {busy_w[1], done_w[1], clr_w[1]}, 0);

    // New operation after the aborted one
    run_op(1, 16'h00FF, 7, 1, 25, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
